hilo_muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit owning the HI/LO register pair. Replaces the single-cycle

---
 rtl/hilo_muldiv_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Shift-add multiply and restoring divide, one result bit per clock, with signed fix-up.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             dbz_save_q, dbz_save_d;

  logic             is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  // Multiply: acc_lo holds the multiplier bits still to consume, acc_hi the running sum.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod      = {acc_hi_q, acc_lo_q};

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    dbz_save_d = dbz_save_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d    = S_PREP;
          op_d       = op;
          a_d        = operand_a;
          b_d        = operand_b;
          cnt_d      = '0;
          dbz_save_d = dbz_q;
          dbz_d      = 1'b0;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
          dbz_d   = dbz_save_q;
        end else if (is_div && (b_q == '0)) begin
          state_d = S_IDLE;
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d  = S_CALC;
          acc_hi_d = '0;
          acc_lo_d = is_div ? a_mag : b_mag;
          opnd_d   = is_div ? b_mag : a_mag;
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          cnt_d    = '0;
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          dbz_d   = dbz_save_q;
        end else begin
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_d = div_diff[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_d = div_shift[WIDTH-1:0];
              acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
          dbz_d   = dbz_save_q;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (is_div) begin
            lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
          end else begin
            {hi_d, lo_d} = neg_q_q ? -prod : prod;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      dbz_save_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      dbz_save_q <= dbz_save_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: latency, arithmetic corner cases,
// divide-by-zero, busy/start interaction, mthi/mtlo, flush and mid-operation reset.
module tb_hilo_muldiv_sequencer;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        flush, hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation; lat is the edge index after E0 at which done is first seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 60; n++) begin
      if (busy) busy_cycles++;
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; op = OP_MULTU; operand_a = 32'h1234; operand_b = 32'h5678;
    flush = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555;
    repeat (3) tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multu_latency();
    int lat, bc;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
    checks++; if (bc !== 34) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=34", bc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy_overlap got=%b exp=0", busy); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=FFFFFFFE", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, lat, bc);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin failures++; $display("FAIL mult_neg got=%h_%h exp=FFFFFFFF_FFFFFFF1", hi, lo); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bc);
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_quot got=%h exp=FFFFFFFD", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_rem got=%h exp=FFFFFFFF", hi); end
    run_op(OP_DIV, 32'h00000064, 32'hFFFFFFF9, lat, bc);
    checks++; if ({hi, lo} !== 64'h00000002_FFFFFFF2) begin failures++; $display("FAIL div_pos_by_neg got=%h_%h exp=00000002_FFFFFFF2", hi, lo); end
  endtask

  task automatic test_div_edges();
    int lat, bc;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if ({hi, lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_minneg_by_m1 got=%h_%h exp=00000000_80000000", hi, lo); end
    run_op(OP_DIVU, 32'h00000064, 32'h00000007, lat, bc);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    checks++; if ({hi, lo} !== 64'h00000002_0000000E) begin failures++; $display("FAIL divu_64_7 got=%h_%h exp=00000002_0000000E", hi, lo); end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, lat, bc);
    checks++; if ({hi, lo} !== 64'h0000000F_0FFFFFFF) begin failures++; $display("FAIL divu_big got=%h_%h exp=0000000F_0FFFFFFF", hi, lo); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(OP_DIVU, 32'h00000005, 32'h00000000, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if ({hi, lo} !== 64'h00000005_FFFFFFFF) begin failures++; $display("FAIL dbz_hilo got=%h_%h exp=00000005_FFFFFFFF", hi, lo); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    repeat (3) tick();
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_sticky got=%b exp=1", div_by_zero); end
    op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_cleared_on_start got=%b exp=0", div_by_zero); end
    for (int n = 0; n < 60 && !done; n++) tick();
    checks++; if ({hi, lo} !== 64'h00000000_00000006) begin failures++; $display("FAIL multu_small got=%h_%h exp=0_6", hi, lo); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    op = OP_MULTU; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd3; start = 1'b1;
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_during_op got=%b exp=1", busy); end
    lat = -1;
    for (int n = 6; n <= 60; n++) begin
      tick();
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 34) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=34", lat); end
    checks++; if ({hi, lo} !== 64'h00000000_0000003F) begin failures++; $display("FAIL ignored_start_result got=%h_%h exp=0_3F", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
    tick();
    hi_we = 1'b0;
    wdata = 32'h22222222;
    tick();
    lo_we = 1'b0;
    checks++; if ({hi, lo} !== 64'h0BADF00D_22222222) begin failures++; $display("FAIL mthi_mtlo got=%h_%h exp=0BADF00D_22222222", hi, lo); end
    hi_we = 1'b1; wdata = 32'h11111111;
    tick();
    // Start together with a write: the write must be dropped.
    op = OP_MULTU; operand_a = 32'd1; operand_b = 32'd1; start = 1'b1; lo_we = 1'b1; wdata = 32'h99999999;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== 64'h11111111_22222222) begin failures++; $display("FAIL start_drops_write got=%h_%h exp=11111111_22222222", hi, lo); end
    for (int n = 0; n < 60 && !done; n++) tick();
    checks++; if ({hi, lo} !== 64'h00000000_00000001) begin failures++; $display("FAIL multu_one got=%h_%h exp=0_1", hi, lo); end
  endtask

  task automatic test_flush_and_reset();
    int lat, bc;
    int seen_done;
    run_op(OP_DIV, 32'h00000009, 32'h00000000, lat, bc);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    op = OP_MULTU; operand_a = 32'h12345678; operand_b = 32'h9ABCDEF0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'h11111111_11111111) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=11111111_11111111", hi, lo); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL flush_dbz_restored got=%b exp=1", div_by_zero); end
    seen_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) seen_done++;
      tick();
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen_done); end
    // Flush together with start in IDLE cancels the start.
    op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_cancels_start got=%b exp=0", busy); end
    op = OP_MULT; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin failures++; $display("FAIL midop_reset_flags got=%b exp=000", {busy, done, div_by_zero}); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midop_reset_hilo got=%h_%h exp=0_0", hi, lo); end
    rst_n = 1'b1;
    repeat (40) tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL after_reset_idle got=%b exp=00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_signed();
    test_div_edges();
    test_div_zero();
    test_busy_ignore();
    test_mthi_mtlo();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
